// File: rtl/sig_change_logger_if.sv
// Record stream from the change logger to its reader: valid/ready with show-ahead data.
interface sig_change_logger_if #(
    parameter int DW = 24
);
    logic          evt_valid;
    logic          evt_ready;
    logic [DW-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_data, output evt_ready);
endinterface

// File: rtl/sig_change_logger.sv
// Timestamped change logger: records {ts, sig_in} into a show-ahead FIFO on each sampled change while monitoring.
// Optional SIG_LOG_MASK_EN adds sig_mask_i so only selected bits trigger a record in RUN.
module sig_change_logger #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     mon_on_i,
    input  logic                     mon_off_i,
    input  logic [WIDTH-1:0]         sig_in_i,
`ifdef SIG_LOG_MASK_EN
    input  logic [WIDTH-1:0]         sig_mask_i,
`endif
    sig_change_logger_if.master      evt,
    output logic                     active_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = TS_WIDTH + WIDTH;

    typedef enum logic [1:0] {S_OFF, S_PRIME, S_RUN} state_e;

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [WIDTH-1:0]    prev_q;
    logic                overflow_q, overflow_d;
    logic [AW:0]         count_q, count_d;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]       mem_q [DEPTH];

    logic changed, push, take_on, pop, full, push_ok, drop;

`ifdef SIG_LOG_MASK_EN
    assign changed = |((sig_in_i ^ prev_q) & sig_mask_i);
`else
    assign changed = sig_in_i != prev_q;
`endif

    // mon_off dominates mon_on and suppresses any record at the edge it is sampled
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        take_on = 1'b0;
        unique case (state_q)
            S_OFF: begin
                if (mon_on_i && !mon_off_i) begin
                    state_d = S_PRIME;
                    take_on = 1'b1;
                end
            end
            S_PRIME: begin
                state_d = mon_off_i ? S_OFF : S_RUN;
                push    = !mon_off_i;
            end
            S_RUN: begin
                push = !mon_off_i && changed;
                if (mon_off_i) begin
                    state_d = S_OFF;
                end else if (mon_on_i) begin
                    state_d = S_PRIME;
                    take_on = 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    assign pop     = evt.evt_valid && evt.evt_ready;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign push_ok = push && (!full || pop);
    assign drop    = push && !push_ok;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (take_on) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_OFF;
            ts_q       <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + 1'b1;
            prev_q     <= sig_in_i;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_q[wr_ptr_q] <= {ts_q, sig_in_i};
        end
    end

    assign evt.evt_valid = count_q != '0;
    assign evt.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign active_o      = state_q != S_OFF;
    assign overflow_o    = overflow_q;
    assign count_o       = count_q;
endmodule

// File: tb/tb_sig_change_logger.sv
// Bench for sig_change_logger: vector table, scoreboard of expected records, hand-written corner sequences.
`timescale 1ns/1ps
module tb_sig_change_logger;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_on = 1'b0;
    logic       mon_off = 1'b0;
    logic [7:0] sig_in = 8'h00;
    logic [7:0] sig_mask = 8'hFF;
    logic       active, overflow;
    logic [3:0] count;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];

    sig_change_logger_if #(.DW(24)) evt_if ();

    sig_change_logger #(.WIDTH(8), .TS_WIDTH(16), .DEPTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mon_on_i   (mon_on),
        .mon_off_i  (mon_off),
        .sig_in_i   (sig_in),
`ifdef SIG_LOG_MASK_EN
        .sig_mask_i (sig_mask),
`endif
        .evt        (evt_if),
        .active_o   (active),
        .overflow_o (overflow),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    // Reference cycle count; equals the DUT timestamp during each cycle
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int unsigned c);
        int n = 0;
        while (cyc != c && n < 1000) begin
            step();
            n++;
        end
        if (cyc != c) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_timeout: at cycle %0d, wanted %0d", cyc, c);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got 0x%0h, expected none", evt_if.evt_data);
            end else begin
                check("record", 32'(evt_if.evt_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] sig;
        logic       exp_valid;
        logic [3:0] exp_count;
        logic       exp_active;
    } vec_t;
    vec_t vecs[6];

    typedef struct {
        int unsigned at;
        logic [7:0]  val;
    } chg_t;
    chg_t chgs[3];

    initial begin
        logic [23:0] hold;
        int unsigned c0;

        for (int i = 0; i < 6; i++) vecs[i] = '{8'(i), 1'b0, 4'd0, 1'b0};
        chgs[0] = '{20, 8'h11};
        chgs[1] = '{21, 8'h22};
        chgs[2] = '{25, 8'h33};
        evt_if.evt_ready = 1'b1;

        repeat (3) step();
        check("rst_valid", 32'(evt_if.evt_valid), 0);
        check("rst_data", 32'(evt_if.evt_data), 0);
        check("rst_active", 32'(active), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_count", 32'(count), 0);
        rst = 1'b0;

        // Changes while OFF never produce records
        for (int i = 0; i < 6; i++) begin
            sig_in = vecs[i].sig;
            step();
            check("off_valid", 32'(evt_if.evt_valid), 32'(vecs[i].exp_valid));
            check("off_count", 32'(count), 32'(vecs[i].exp_count));
            check("off_active", 32'(active), 32'(vecs[i].exp_active));
        end

        goto(10);
        sig_in = 8'h3C;
        mon_on = 1'b1;
        exp_q.push_back({16'd11, 8'h3C});
        step();
        mon_on = 1'b0;
        check("on_active_n1", 32'(active), 1);
        check("on_valid_n1", 32'(evt_if.evt_valid), 0);
        step();
        check("on_valid_n2", 32'(evt_if.evt_valid), 1);
        check("on_data_n2", 32'(evt_if.evt_data), 32'({16'd11, 8'h3C}));

        for (int i = 0; i < 3; i++) begin
            goto(chgs[i].at);
            sig_in = chgs[i].val;
            exp_q.push_back({16'(chgs[i].at), chgs[i].val});
        end
        repeat (2) step();
        check("run_drained", 32'(exp_q.size()), 0);
        check("run_count", 32'(count), 0);

        // Fill past capacity with the reader stalled
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sig_in = 8'h40 + 8'(i);
            if (i < 8) exp_q.push_back({16'(cyc), sig_in});
            step();
        end
        check("ovf_count", 32'(count), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head", 32'(evt_if.evt_data), 32'(exp_q[0]));
        hold = evt_if.evt_data;
        step();
        check("ovf_hold", 32'(evt_if.evt_data), 32'(hold));
        evt_if.evt_ready = 1'b1;
        repeat (8) step();
        check("ovf_drain_count", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        mon_on = 1'b1;
        exp_q.push_back({16'(cyc + 1), sig_in});
        step();
        mon_on = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
        check("reprime_active", 32'(active), 1);
        step();
        check("reprime_valid", 32'(evt_if.evt_valid), 1);

        // mon_on with mon_off in RUN: off wins, the change on this edge is not recorded
        mon_on = 1'b1;
        mon_off = 1'b1;
        sig_in = 8'h77;
        step();
        mon_on = 1'b0;
        mon_off = 1'b0;
        check("both_active", 32'(active), 0);
        step();
        check("both_valid", 32'(evt_if.evt_valid), 0);
        check("both_count", 32'(count), 0);

        // mon_off during PRIME suppresses the initial record
        mon_on = 1'b1;
        step();
        mon_on = 1'b0;
        mon_off = 1'b1;
        sig_in = 8'h55;
        step();
        mon_off = 1'b0;
        check("prime_off_active", 32'(active), 0);
        step();
        check("prime_off_valid", 32'(evt_if.evt_valid), 0);

        // Reset with five records queued
        evt_if.evt_ready = 1'b0;
        mon_on = 1'b1;
        exp_q.push_back({16'(cyc + 1), sig_in});
        step();
        mon_on = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            sig_in = 8'h80 + 8'(i);
            exp_q.push_back({16'(cyc), sig_in});
            step();
        end
        check("pre_rst_count", 32'(count), 5);
        rst = 1'b1;
        exp_q.delete();
        sig_in = 8'hA5;
        step();
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_valid", 32'(evt_if.evt_valid), 0);
        check("mid_rst_active", 32'(active), 0);
        rst = 1'b0;
        step();
        check("post_rst_count", 32'(count), 0);
        check("post_rst_ts_ref", 32'(cyc), 1);

`ifdef SIG_LOG_MASK_EN
        evt_if.evt_ready = 1'b1;
        sig_mask = 8'h01;
        sig_in = 8'h00;
        mon_on = 1'b1;
        exp_q.push_back({16'(cyc + 1), 8'h00});
        step();
        mon_on = 1'b0;
        step();
        sig_in = 8'hF0;
        step();
        sig_in = 8'hF1;
        exp_q.push_back({16'(cyc), 8'hF1});
        step();
        repeat (3) step();
        check("mask_drained", 32'(exp_q.size()), 0);
`endif

        evt_if.evt_ready = 1'b1;
        c0 = cyc;
        repeat (3) step();
        check("final_queue", 32'(exp_q.size()), 0);
        check("final_count", 32'(count), 0);
        check("final_cycles", 32'(cyc - c0), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sig_change_logger.md
# sig_change_logger

Synthesizable hardware counterpart of a simulation signal monitor. The block watches a WIDTH-bit input and, while enabled, pushes a timestamped record into an internal FIFO every cycle the sampled value differs from the previous sample. It also pushes one unconditional record when monitoring is turned on. Records drain to a downstream reader over a valid/ready interface. The block sits beside the logic under observation and feeds a debug readout or trace buffer.

## Interface
- WIDTH, 8: width of the observed signal.
- TS_WIDTH, 16: width of the free-running timestamp.
- DEPTH, 8: FIFO entries; power of two, minimum 2.

- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- mon_on  input  1  one-cycle pulse: enable monitoring and emit an initial record.
- mon_off  input  1  one-cycle pulse: disable monitoring.
- sig_in  input  WIDTH  observed signal, sampled every edge.
- evt_valid  output  1  FIFO head holds a record.
- evt_ready  input  1  reader accepts the head record this cycle.
- evt_data  output  TS_WIDTH+WIDTH  {timestamp, value} of the FIFO head.
- active  output  1  monitoring is enabled.
- overflow  output  1  sticky flag: a record was dropped.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Timestamp: a TS_WIDTH counter that starts at 0 after reset, increments every cycle, and wraps from all-ones to 0 with no flag.
- prev register: holds the last sampled sig_in and updates every cycle in all states.
- FSM states:
  - OFF: reset state.
  - PRIME: one cycle.
  - RUN.
- FSM transitions:
  - OFF --mon_on--> PRIME.
  - PRIME --> RUN unconditionally, unless mon_off is asserted, in which case PRIME --> OFF.
  - RUN --mon_off--> OFF.
  - RUN --mon_on--> PRIME (re-prime).
  - mon_on and mon_off asserted in the same cycle: mon_off wins in every state.
- Record generation:
  - PRIME: push {ts, sig_in} unconditionally.
  - RUN: push {ts, sig_in} when sig_in != prev.
  - OFF: never push.
  - ts is the counter value at the sampling edge.
- active is 1 in PRIME and RUN.
- mon_on clears overflow in the same edge it is taken. The record pushed in PRIME is then subject to the normal full check.
- FIFO:
  - Show-ahead: evt_data equals the head whenever evt_valid=1.
  - Pop occurs when evt_valid && evt_ready.
  - Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the record is dropped and overflow is set.
  - Simultaneous push and pop leaves count unchanged.
- evt_ready is ignored while evt_valid=0.
- evt_data is held stable while evt_valid=1 and evt_ready=0.
- Reset mid-operation: the FIFO is flushed, the FSM returns to OFF, and no record is emitted for the reset cycle.

## Timing
- Reset values:
  - evt_valid=0, evt_data=0, active=0, overflow=0, count=0.
  - Timestamp=0, prev=0.
- Latency with the FIFO empty: a change sampled at edge N gives evt_valid=1 after edge N and is visible in cycle N+1.
- mon_on sampled at edge N:
  - active=1 from cycle N+1.
  - The PRIME record samples sig_in at edge N+1 and is visible in cycle N+2.
- mon_off sampled at edge N: no record is generated at edge N or later; records already queued still drain.
- Throughput: one push and one pop per cycle.

## Configuration
- SIG_LOG_MASK_EN:
  - Defined: adds port sig_mask (input, WIDTH). In RUN, a record is pushed only when (sig_in ^ prev) & sig_mask is nonzero. The PRIME record is unaffected by the mask. Recorded values are always the full unmasked sig_in.
  - Undefined: the port is absent and every bit participates in change detection.

## Test plan
- After reset, drive sig_in 0x00→0x05 with no mon_on -> evt_valid stays 0, count=0, active=0.
- mon_on at cycle 10 with sig_in=0x3C held -> exactly one record, {ts=11, 0x3C}, with evt_valid high in cycle 12, active=1 from cycle 11.
- RUN with evt_ready=1, sig_in changes at cycles 20, 21, 25 -> three records with ts 20, 21, 25 in order; no record for unchanged cycles.
- DEPTH=8, evt_ready=0, ten changes -> count=8, overflow=1, the first eight records are retained in order; a following mon_on clears overflow.
- Same-cycle mon_on and mon_off in RUN -> active=0 next cycle, no PRIME record; rst asserted with count=5 -> count=0, evt_valid=0 next cycle.
- SIG_LOG_MASK_EN, sig_mask=0x01, sig_in 0x00→0xF0→0xF1 -> only the 0xF1 change is recorded after the PRIME record.
